// File: rtl/core_sequencer_pkg.sv
// Shared state encoding, word width and PC step for core_sequencer and its watchdog.
package core_sequencer_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] PC_STEP = 32'd4;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE   = 3'd0;
  localparam seq_state_t S_FETCH  = 3'd1;
  localparam seq_state_t S_DECODE = 3'd2;
  localparam seq_state_t S_EXEC   = 3'd3;
  localparam seq_state_t S_MEM    = 3'd4;
  localparam seq_state_t S_WB     = 3'd5;
  localparam seq_state_t S_HALT   = 3'd6;
  localparam seq_state_t S_ERROR  = 3'd7;

endpackage

// File: rtl/core_sequencer_watchdog.sv
// seq_watchdog: counts wait cycles of an outstanding memory request.
// expired is high once TIMEOUT-1 cycles have gone unacknowledged, i.e. during the last allowed wait cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: one-instruction-at-a-time F/D/E/M/WB control FSM for RV32I; FETCH/MEM stall until ack or timeout.
// Outputs decode from registered state only. SEQ_PERF_CNT_EN adds retired_cnt/cycle_cnt.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic [WORD-1:0] instr,
  input  logic            dec_regWrite,
  input  logic            dec_memWrite,
  input  logic            dec_isLoad,
  input  logic            dec_finish,
  input  logic            dec_illegal,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            halted,
  output logic            error,
  output logic [WORD-1:0] pc
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     cycle_cnt
`endif
);

  seq_state_t      state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic            dmem_we_q, dmem_we_d;
  logic            wd_clr, wd_inc, wd_expired;

  seq_watchdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Every entry into FETCH or MEM is a state change, so clearing on any change restarts the count.
  assign wd_clr = (state_d != state_q);
  assign wd_inc = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    dmem_we_d = dmem_we_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        if (dec_illegal)     state_d = S_ERROR;
        else if (dec_finish) state_d = S_HALT;
        else                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_isLoad || dec_memWrite) begin
          dmem_we_d = dec_memWrite;
          state_d   = S_MEM;
        end else if (dec_regWrite) begin
          state_d = S_WB;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          dmem_we_d = 1'b0;
          if (dmem_we_q) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          dmem_we_d = 1'b0;
          state_d   = S_ERROR;
        end
      end
      S_WB: begin
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      dmem_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      dmem_we_q <= dmem_we_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = dmem_we_q;
  assign rf_we     = (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign error     = (state_q == S_ERROR);
  assign pc        = pc_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        retire, active;

  // An ECALL counts as retired when it reaches HALT; illegal and timed-out instructions never retire.
  assign retire = (state_q == S_WB)
               || ((state_q == S_EXEC) && (state_d == S_FETCH))
               || ((state_q == S_MEM) && dmem_ack && dmem_we_q)
               || ((state_q == S_DECODE) && (state_d == S_HALT));
  assign active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    if (retire) retired_cnt_d = retired_cnt_q + 32'd1;
    if (active) cycle_cnt_d   = cycle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: random programs with random memory latency, checked against a per-instruction timing model.
module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_NOP = 3, C_ECALL = 4, C_ILL = 5, C_ILLFIN = 6, C_ALU2 = 7;
  localparam int EV_F = 0, EV_D = 1, EV_RF = 2, EV_H = 3, EV_E = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, halted, error;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic        dec_regWrite, dec_memWrite, dec_isLoad, dec_finish, dec_illegal;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt, retired_cnt2, cycle_cnt2;
`endif

  logic        rst2_n, start2, imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2, rf_we2, halted2, error2;
  logic [31:0] imem_addr2, imem_rdata2, instr2, pc2;
  logic        dec_regWrite2, dec_memWrite2, dec_isLoad2, dec_finish2, dec_illegal2;

  // Bench decoder: low three bits select the instruction class.
  // Result bits: {regWrite, memWrite, isLoad, finish, illegal}
  function automatic logic [4:0] decode(input logic [31:0] w);
    case (w[2:0])
      3'd1:    decode = 5'b10100;
      3'd2:    decode = 5'b01000;
      3'd3:    decode = 5'b00000;
      3'd4:    decode = 5'b00010;
      3'd5:    decode = 5'b00001;
      3'd6:    decode = 5'b00011;
      default: decode = 5'b10000;
    endcase
  endfunction

  assign {dec_regWrite, dec_memWrite, dec_isLoad, dec_finish, dec_illegal} = decode(instr);
  assign {dec_regWrite2, dec_memWrite2, dec_isLoad2, dec_finish2, dec_illegal2} = decode(instr2);

  core_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .dec_regWrite(dec_regWrite), .dec_memWrite(dec_memWrite),
    .dec_isLoad(dec_isLoad), .dec_finish(dec_finish), .dec_illegal(dec_illegal),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .halted(halted), .error(error), .pc(pc)
`ifdef SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MEM_TIMEOUT(1)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .instr(instr2), .dec_regWrite(dec_regWrite2), .dec_memWrite(dec_memWrite2),
    .dec_isLoad(dec_isLoad2), .dec_finish(dec_finish2), .dec_illegal(dec_illegal2),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_ack(dmem_ack2),
    .rf_we(rf_we2), .halted(halted2), .error(error2), .pc(pc2)
`ifdef SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt2), .cycle_cnt(cycle_cnt2)
`endif
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t         expq[$];
  logic [31:0] prog_word[$];
  int          prog_li[$];
  int          prog_ld[$];
  int          fetch_idx = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic        halted_p = 1'b0;
  logic        error_p = 1'b0;

  int          m_t, m_t0, m_end, m_ret;
  logic [31:0] m_pc;

  always @(posedge clk) cyc = cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_F:    kname = "fetch";
      EV_D:    kname = "dmem";
      EV_RF:   kname = "rf_write";
      EV_H:    kname = "halt";
      default: kname = "error";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event at cycle %0d a=%h b=%h", kname(kind), cyc, a, b);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b) begin
        n_bad++;
        $display("FAIL %s: got cyc=%0d a=%h b=%h, expected %s cyc=%0d a=%h b=%h",
                 kname(kind), cyc, a, b, kname(e.kind), e.cyc, e.a, e.b);
      end
    end
  endtask

  // Memory responder: acks after the programmed number of wait cycles; stray acks when idle must be ignored.
  int icnt = 0, dcnt = 0;
  always @(negedge clk) begin
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (!rst_n) begin
      icnt = 0;
      dcnt = 0;
    end else begin
      if (imem_req) begin
        if (fetch_idx < prog_word.size() && icnt == prog_li[fetch_idx]) begin
          imem_ack   = 1'b1;
          imem_rdata = prog_word[fetch_idx];
          fetch_idx++;
          icnt = 0;
        end else begin
          icnt++;
        end
      end else begin
        icnt = 0;
        imem_ack = ($urandom_range(0, 3) == 0);
      end
      if (dmem_req) begin
        if (fetch_idx > 0 && dcnt == prog_ld[fetch_idx-1]) begin
          dmem_ack = 1'b1;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end else begin
        dcnt = 0;
        dmem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (imem_req && imem_ack) observe(EV_F, imem_addr, 32'd0);
      if (dmem_req && dmem_ack) observe(EV_D, {31'd0, dmem_we}, pc);
      if (rf_we)                observe(EV_RF, pc, instr);
      if (halted && !halted_p)  observe(EV_H, pc, 32'd0);
      if (error && !error_p)    observe(EV_E, pc, 32'd0);
      if (halted || error) begin
        n_cmp++;
        if (imem_req || dmem_req || rf_we) begin
          n_bad++;
          $display("FAIL quiet_after_stop: imem_req=%b dmem_req=%b rf_we=%b, all required 0",
                   imem_req, dmem_req, rf_we);
        end
      end
    end
    halted_p = halted;
    error_p  = error;
  end

  task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b;
    expq.push_back(e);
  endtask

  // Reference model: each instruction costs fetch-wait + D + E (+ M wait) (+ WB) cycles; m_t is the next fetch's first cycle.
  task automatic add_instr(input int cls, input int li, input int ld);
    logic [31:0] w;
    int ta;
    w = $urandom;
    w[2:0] = 3'(cls);
    prog_word.push_back(w);
    prog_li.push_back(li);
    prog_ld.push_back(ld);
    if (li >= TMO) begin
      m_end = m_t + TMO;
      push(EV_E, m_end, m_pc, 32'd0);
      return;
    end
    ta = m_t + li;
    push(EV_F, ta, m_pc, 32'd0);
    case (cls)
      C_ECALL: begin
        m_end = ta + 2;
        push(EV_H, m_end, m_pc, 32'd0);
        m_ret++;
      end
      C_ILL, C_ILLFIN: begin
        m_end = ta + 2;
        push(EV_E, m_end, m_pc, 32'd0);
      end
      C_NOP: begin
        m_t = ta + 3;
        m_pc = m_pc + 32'd4;
        m_ret++;
      end
      C_LD, C_ST: begin
        if (ld >= TMO) begin
          m_end = ta + 3 + TMO;
          push(EV_E, m_end, m_pc, 32'd0);
        end else begin
          push(EV_D, ta + 3 + ld, (cls == C_ST) ? 32'd1 : 32'd0, m_pc);
          if (cls == C_LD) begin
            push(EV_RF, ta + 4 + ld, m_pc, w);
            m_t = ta + 5 + ld;
          end else begin
            m_t = ta + 4 + ld;
          end
          m_pc = m_pc + 32'd4;
          m_ret++;
        end
      end
      default: begin
        push(EV_RF, ta + 3, m_pc, w);
        m_t = ta + 4;
        m_pc = m_pc + 32'd4;
        m_ret++;
      end
    endcase
  endtask

  task automatic reset_main();
    mon_en = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ctrl", {26'd0, imem_req, dmem_req, dmem_we, rf_we, halted, error}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_retired_cnt", retired_cnt, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
  endtask

  task automatic run(input int n_rand, input int tcls, input int tli, input int tld);
    int pick;
    int cls_tab[5] = '{C_ALU, C_LD, C_ST, C_NOP, C_ALU2};
    reset_main();
    prog_word.delete(); prog_li.delete(); prog_ld.delete(); expq.delete();
    fetch_idx = 0;
    m_ret = 0;
    m_pc  = RST_PC;
    @(negedge clk);
    m_t  = cyc + 1;
    m_t0 = m_t;
    add_instr(C_ALU, 0, 0);
    add_instr(C_LD, 0, 3);
    add_instr(C_ST, 0, 0);
    for (int i = 0; i < n_rand; i++) begin
      pick = $urandom_range(0, 4);
      add_instr(cls_tab[pick], $urandom_range(0, 3), $urandom_range(0, 3));
    end
    add_instr(C_ALU, TMO - 1, 0);
    add_instr(C_ST, 1, TMO - 1);
    add_instr(tcls, tli, tld);
    start  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4000 && expq.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events still pending after cycle budget, required 0", expq.size());
    end
    repeat (6) @(negedge clk);
    chk("final_pc", pc, m_pc);
    chk("sticky_flags", {30'd0, halted, error}, (tcls == C_ECALL && tli < TMO) ? 32'd2 : 32'd1);
`ifdef SEQ_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("cycle_cnt", cycle_cnt, m_end - m_t0);
`endif
    mon_en = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wrap_test();
    logic [31:0] w;
    rst2_n = 1'b0; start2 = 1'b0; imem_ack2 = 1'b0; dmem_ack2 = 1'b0; imem_rdata2 = '0;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
    w = $urandom;
    w[2:0] = 3'(C_LD);
    start2 = 1'b1; imem_ack2 = 1'b1; imem_rdata2 = w;
    @(negedge clk);
    chk("wrap_fetch_req", {31'd0, imem_req2}, 32'd1);
    chk("wrap_idle_ack_ignored", instr2, 32'd0);
    @(negedge clk);
    start2 = 1'b0; imem_ack2 = 1'b0;
    chk("wrap_instr_latched", instr2, w);
    repeat (2) @(negedge clk);
    chk("wrap_mem_req", {30'd0, dmem_req2, dmem_we2}, 32'd2);
    #2 rst2_n = 1'b0;
    #1;
    chk("wrap_async_dmem_req", {31'd0, dmem_req2}, 32'd0);
    chk("wrap_async_instr", instr2, 32'd0);
    chk("wrap_async_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_async_ctrl", {27'd0, imem_req2, dmem_we2, rf_we2, halted2, error2}, 32'd0);
    @(negedge clk);
    imem_ack2 = 1'b1; dmem_ack2 = 1'b1;
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("wrap_late_ack_ignored", {29'd0, imem_req2, dmem_req2, error2}, 32'd0);
    chk("wrap_late_ack_instr", instr2, 32'd0);
    imem_ack2 = 1'b0; dmem_ack2 = 1'b0;
    w = $urandom;
    w[2:0] = 3'(C_ALU);
    start2 = 1'b1; imem_ack2 = 1'b1; imem_rdata2 = w;
    repeat (2) @(negedge clk);
    start2 = 1'b0; imem_ack2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_wb_rf_we", {31'd0, rf_we2}, 32'd1);
    chk("wrap_wb_pc", pc2, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc_zero", pc2, 32'd0);
    chk("wrap_fetch_addr", imem_addr2, 32'd0);
    chk("wrap_refetch_req", {31'd0, imem_req2}, 32'd1);
    @(negedge clk);
    chk("wrap_timeout1", {30'd0, imem_req2, error2}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    wrap_test();
    run(20, C_ECALL, 0, 0);
    run(10, C_ILL, 1, 0);
    run(4, C_ILLFIN, 0, 0);
    run(5, C_ALU, NEVER, 0);
    run(5, C_LD, 2, NEVER);
    run(15, C_ECALL, 3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that drives one instruction at a time through fetch, decode, execute, memory and writeback for the RV32I datapath. It sits between instruction/data memory (req/ack handshakes) and the combinational instruction decoder. It owns the PC and the instruction register, and issues one-cycle strobes for the register-file write. Handles ECALL halt, illegal-instruction trap and memory-timeout trap.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_TIMEOUT, 16, max wait cycles for any ack before trapping; must be ≥1

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin execution; sampled only in IDLE
- imem_req  out  1  instruction fetch request
- imem_addr  out  WORD  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  WORD  fetched instruction
- instr  out  WORD  instruction register, fed to decoder
- dec_regWrite, dec_memWrite, dec_isLoad, dec_finish, dec_illegal  in  1 each  decoder outputs for instr
- dmem_req  out  1  data access request
- dmem_we  out  1  store when 1, load when 0; valid while dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc  out  WORD  current PC
- halted  out  1  sticky, ECALL executed
- error  out  1  sticky, illegal instruction or timeout
- retired_cnt, cycle_cnt  out  32 each  only with SEQ_PERF_CNT_EN

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1 until ack. On imem_ack: instr<=imem_rdata -> DECODE.
- DECODE: one cycle. Priority: dec_illegal -> ERROR; dec_finish -> HALT; else -> EXEC.
- EXEC: one cycle. dec_isLoad|dec_memWrite -> MEM; else dec_regWrite -> WB; else pc+=4 -> FETCH.
- MEM: dmem_req=1, dmem_we=dec_memWrite, held until dmem_ack. On ack: load -> WB; store -> pc+=4 -> FETCH.
- WB: rf_we=1 for exactly this cycle; pc+=4 -> FETCH.
- HALT and ERROR: absorbing until rst_n. halted or error is held at 1. No requests issued.
- PC arithmetic: 32-bit, modulo 2^32 (0xFFFF_FFFC+4 -> 0). PC does not change in DECODE, HALT or ERROR.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments on each cycle the req is high without ack. When it reaches MEM_TIMEOUT without ack, the next state is ERROR and the req drops.
- An ack arriving while no req is outstanding is ignored. start outside IDLE is ignored.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, imem_req=dmem_req=dmem_we=rf_we=0, halted=error=0, counters=0.

## Timing
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Zero-wait memory (ack in the same cycle req rises) is accepted; that cycle is the access cycle.
- Latency, zero-wait: ALU/LUI 4 cycles (F,D,E,WB); load 5 (F,D,E,M,WB); store 4 (F,D,E,M); ECALL 2 (F,D) then HALT.
- Each wait cycle adds 1 to FETCH or MEM.
- Reset asserted mid-instruction: immediately returns to IDLE. Outstanding requests are dropped asynchronously. A subsequent ack is ignored.

## Configuration
- SEQ_PERF_CNT_EN defined: retired_cnt and cycle_cnt ports exist.
  - cycle_cnt increments every cycle the state is not IDLE, HALT or ERROR.
  - retired_cnt increments once per completed instruction: WB exit, store ack, EXEC->FETCH, and DECODE->HALT for ECALL.
  - Both wrap at 2^32.
- Not defined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- Shared package: seq_state_t enum, PC_STEP=4 constant, WORD width. Opcode constants stay in the existing defines.
- One sub-module: seq_watchdog, the parameterised wait counter with clear/inc inputs and an expired output. It is instantiated once and shared by FETCH and MEM.

## Test plan
- Reset with RESET_PC=0x100, start pulse, zero-wait memory, ADDI -> imem_addr=0x100; rf_we high in cycle 4; pc=0x104 on return to FETCH.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we one cycle after ack, total 8 cycles.
- Store -> dmem_we=1, rf_we never asserted, pc+=4 after ack.
- ECALL at pc=0x20 -> halted=1 two cycles after start of fetch, pc stays 0x20, no further imem_req; retired_cnt=1 with SEQ_PERF_CNT_EN.
- imem_ack withheld with MEM_TIMEOUT=16 -> error=1 after 16 req cycles, imem_req drops. Illegal instruction -> error=1 after DECODE.
- rst_n asserted mid-MEM with pc=0xFFFF_FFFC -> outputs return to reset values asynchronously. Separately, a WB at pc=0xFFFF_FFFC wraps pc to 0.
